// File: rtl/idecode.sv
// idecode: RV32I decode stage.
// Decodes InstrD from the IF/ID register, reads the 32x32 register file
// (written back from WB with write-through), builds the sign-extended
// immediate and registers everything into the ID/EX pipeline register.
// There is no handshake: the ID/EX register loads every cycle, and
// FlushE/reset replace the next E-stage contents with an all-zero bubble.
module idecode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic            IllegalE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  // Major opcodes understood by this decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation encodings seen by the execute stage.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ResultSrc encodings.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Immediate format selector; IMM_NONE yields a zero immediate.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_src_t;

  // Instruction fields.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];

  // Register indices go to the hazard unit without a register stage.
  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  // Decoded controls for the instruction currently in ID.
  logic       reg_write_d;
  logic [1:0] result_src_d;
  logic       mem_write_d;
  logic       jump_d;
  logic       branch_d;
  logic [2:0] alu_control_d;
  logic       alu_src_d;
  logic       illegal_d;
  imm_src_t   imm_src_d;

  // ALU-op decode shared by R-type and I-ALU; funct7[5] only matters for
  // R-type add/sub, so the I-ALU path passes sub_sel=0 (addi never subtracts).
  logic       alu_legal;
  logic [2:0] alu_op;
  logic       sub_sel;

  assign sub_sel = (opcode == OP_RTYPE) && funct7_5;

  // Map funct3 (and funct7[5] for R-type) onto the ALU operation.
  always_comb begin
    alu_legal = 1'b1;
    alu_op    = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_legal = 1'b0;
    endcase
  end

  // Main decoder: anything unrecognised leaves all controls low and flags illegal.
  always_comb begin
    reg_write_d   = 1'b0;
    result_src_d  = RES_ALU;
    mem_write_d   = 1'b0;
    jump_d        = 1'b0;
    branch_d      = 1'b0;
    alu_control_d = ALU_ADD;
    alu_src_d     = 1'b0;
    illegal_d     = 1'b0;
    imm_src_d     = IMM_NONE;
    case (opcode)
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = RES_MEM;
        alu_src_d    = 1'b1;
        imm_src_d    = IMM_I;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = IMM_S;
      end
      OP_RTYPE: begin
        if (alu_legal) begin
          reg_write_d   = 1'b1;
          alu_control_d = alu_op;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_IALU: begin
        if (alu_legal) begin
          reg_write_d   = 1'b1;
          alu_control_d = alu_op;
          alu_src_d     = 1'b1;
          imm_src_d     = IMM_I;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          branch_d      = 1'b1;
          alu_control_d = ALU_SUB;
          imm_src_d     = IMM_B;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_JAL: begin
        jump_d       = 1'b1;
        reg_write_d  = 1'b1;
        result_src_d = RES_PC4;
        imm_src_d    = IMM_J;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Immediate extender; every format sign-extends from InstrD[31].
  logic [XLEN-1:0] imm_ext_d;

  // Assemble the immediate for the selected format.
  always_comb begin
    imm_ext_d = '0;
    case (imm_src_d)
      IMM_I: imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                          InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm_ext_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                          InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext_d = '0;
    endcase
  end

  // Register file storage. Entry 0 is never written and is masked on read.
  logic [XLEN-1:0] regs [NREGS];
  logic            wb_en;

  assign wb_en = RegWriteW && (RdW != 5'd0);

  // Write port: reset clears every entry, otherwise WB writes on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[RdW] <= ResultW;
    end
  end

  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;

  // Read port 1: x0 reads zero, a same-cycle WB write to the index bypasses.
  always_comb begin
    rd1_d = '0;
    if (Rs1D == 5'd0)                  rd1_d = '0;
    else if (wb_en && (RdW == Rs1D))   rd1_d = ResultW;
    else                               rd1_d = regs[Rs1D];
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2_d = '0;
    if (Rs2D == 5'd0)                  rd2_d = '0;
    else if (wb_en && (RdW == Rs2D))   rd2_d = ResultW;
    else                               rd2_d = regs[Rs2D];
  end

  // ID/EX register: reset and flush both load an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      ALUSrcE     <= 1'b0;
      IllegalE    <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      RdE         <= 5'd0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write_d;
      ResultSrcE  <= result_src_d;
      MemWriteE   <= mem_write_d;
      JumpE       <= jump_d;
      BranchE     <= branch_d;
      ALUControlE <= alu_control_d;
      ALUSrcE     <= alu_src_d;
      IllegalE    <= illegal_d;
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      ImmExtE     <= imm_ext_d;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= InstrD[11:7];
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_idecode.sv
// tb_idecode: directed and table-driven checks of the RV32I decode stage.
module tb_idecode;

  logic        clk;
  logic        reset;
  logic        FlushE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic        IllegalE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  idecode dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected E-stage contents.
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic        illegal;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rf [32];
  int          total = 0;
  int          bad   = 0;

  // Single comparison point for every check.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU operation meaning of funct3 for the supported arithmetic ops.
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic subtract);
    case (f3)
      3'b000:  return subtract ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic f3_is_alu(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Reference decode: what the instruction means, field by field.
  function automatic exp_t decode(input logic [31:0] i);
    exp_t        e;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    e = '0;
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'b0000011: begin e.reg_write = 1; e.result_src = 2'b01; e.alu_src = 1; e.imm = imm_i; end
      7'b0100011: begin e.mem_write = 1; e.alu_src = 1; e.imm = imm_s; end
      7'b0110011: begin
        if (f3_is_alu(i[14:12])) begin
          e.reg_write = 1; e.alu_control = alu_of(i[14:12], i[30]);
        end else e.illegal = 1;
      end
      7'b0010011: begin
        if (f3_is_alu(i[14:12])) begin
          e.reg_write = 1; e.alu_src = 1; e.imm = imm_i;
          e.alu_control = alu_of(i[14:12], 1'b0);
        end else e.illegal = 1;
      end
      7'b1100011: begin
        if (i[14:12] == 3'b000) begin
          e.branch = 1; e.alu_control = 3'd1; e.imm = imm_b;
        end else e.illegal = 1;
      end
      7'b1101111: begin e.jump = 1; e.reg_write = 1; e.result_src = 2'b10; e.imm = imm_j; end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  // Register read as seen by ID, including a same-cycle WB write.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wrd == a) return wd;
    return model_rf[a];
  endfunction

  // Driver: apply one cycle of inputs, queue the expected E outputs,
  // update the register model, and return just after the capturing edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc,
                      input logic flush, input logic rst, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
    FlushE = flush; reset = rst; RegWriteW = we; RdW = wrd; ResultW = wd;
    if (rst || flush) begin
      e = '0;
    end else begin
      e          = decode(instr);
      e.rs1      = instr[19:15];
      e.rs2      = instr[24:20];
      e.rd       = instr[11:7];
      e.rd1      = model_read(instr[19:15], we, wrd, wd);
      e.rd2      = model_read(instr[24:20], we, wrd, wd);
      e.pc       = pc;
      e.pc_plus4 = pc + 32'd4;
    end
    exp_q.push_back(e);
    if (rst) begin
      for (int k = 0; k < 32; k++) model_rf[k] = 32'h0;
    end else if (we && wrd != 5'd0) begin
      model_rf[wrd] = wd;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [31:0] instr, input logic [31:0] pc);
    step(instr, pc, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  // Scoreboard: every cycle, check the E outputs against the queued model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb RegWriteE",   {31'h0, RegWriteE},   {31'h0, e.reg_write});
        chk("sb ResultSrcE",  {30'h0, ResultSrcE},  {30'h0, e.result_src});
        chk("sb MemWriteE",   {31'h0, MemWriteE},   {31'h0, e.mem_write});
        chk("sb JumpE",       {31'h0, JumpE},       {31'h0, e.jump});
        chk("sb BranchE",     {31'h0, BranchE},     {31'h0, e.branch});
        chk("sb ALUControlE", {29'h0, ALUControlE}, {29'h0, e.alu_control});
        chk("sb ALUSrcE",     {31'h0, ALUSrcE},     {31'h0, e.alu_src});
        chk("sb IllegalE",    {31'h0, IllegalE},    {31'h0, e.illegal});
        chk("sb RD1E",        RD1E,                 e.rd1);
        chk("sb RD2E",        RD2E,                 e.rd2);
        chk("sb ImmExtE",     ImmExtE,              e.imm);
        chk("sb Rs1E",        {27'h0, Rs1E},        {27'h0, e.rs1});
        chk("sb Rs2E",        {27'h0, Rs2E},        {27'h0, e.rs2});
        chk("sb RdE",         {27'h0, RdE},         {27'h0, e.rd});
        chk("sb PCE",         PCE,                  e.pc);
        chk("sb PCPlus4E",    PCPlus4E,             e.pc_plus4);
      end
    end
  end

  // All E outputs zero, checked against literals.
  task automatic chk_bubble(input string tag);
    chk({tag, " ctrl"}, {24'h0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE}, 32'h0);
    chk({tag, " alu"},  {29'h0, ALUControlE}, 32'h0);
    chk({tag, " rd1"},  RD1E, 32'h0);
    chk({tag, " rd2"},  RD2E, 32'h0);
    chk({tag, " imm"},  ImmExtE, 32'h0);
    chk({tag, " idx"},  {17'h0, Rs1E, Rs2E, RdE}, 32'h0);
    chk({tag, " pc"},   PCE | PCPlus4E, 32'h0);
  endtask

  // Directed sequence with hand-computed literal expectations.
  initial begin
    logic [31:0] instr;
    logic [6:0]  ops [7];
    InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h4; FlushE = 0; reset = 0;
    RegWriteW = 0; RdW = 0; ResultW = 0;
    for (int k = 0; k < 32; k++) model_rf[k] = 32'h0;

    // Reset for two cycles with addi x1,x0,5 on the input.
    step(32'h00500093, 32'h40, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    step(32'h00500093, 32'h40, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    chk_bubble("reset");

    // Every register reads zero after reset (add x0, xi, xi).
    for (int r = 1; r < 32; r++) begin
      run({7'h0, r[4:0], r[4:0], 3'b000, 5'd0, 7'h33}, 32'h80);
      chk("rf zero rd1", RD1E, 32'h0);
      chk("rf zero rd2", RD2E, 32'h0);
    end

    // addi x1,x0,5
    run(32'h00500093, 32'h100);
    chk("addi RegWriteE", {31'h0, RegWriteE}, 32'h1);
    chk("addi ALUSrcE", {31'h0, ALUSrcE}, 32'h1);
    chk("addi ALUControlE", {29'h0, ALUControlE}, 32'h0);
    chk("addi ImmExtE", ImmExtE, 32'h5);
    chk("addi RdE", {27'h0, RdE}, 32'h1);
    chk("addi Rs1E", {27'h0, Rs1E}, 32'h0);
    chk("addi RD1E", RD1E, 32'h0);

    // sub x3,x1,x2 while WB writes x1=5: write-through.
    step(32'h402081B3, 32'h104, 1'b0, 1'b0, 1'b1, 5'd1, 32'h5);
    chk("sub RD1E bypass", RD1E, 32'h5);
    chk("sub ALUControlE", {29'h0, ALUControlE}, 32'h1);
    chk("sub RdE", {27'h0, RdE}, 32'h3);
    chk("sub ALUSrcE", {31'h0, ALUSrcE}, 32'h0);

    // sw x2,8(x1)
    run(32'h0020A423, 32'h108);
    chk("sw MemWriteE", {31'h0, MemWriteE}, 32'h1);
    chk("sw RegWriteE", {31'h0, RegWriteE}, 32'h0);
    chk("sw ImmExtE", ImmExtE, 32'h8);
    chk("sw RD1E stored x1", RD1E, 32'h5);

    // beq x1,x2,-4
    run(32'hFE208EE3, 32'h10C);
    chk("beq BranchE", {31'h0, BranchE}, 32'h1);
    chk("beq ALUControlE", {29'h0, ALUControlE}, 32'h1);
    chk("beq ImmExtE", ImmExtE, 32'hFFFFFFFC);

    // jal x1,8
    run(32'h008000EF, 32'h200);
    chk("jal JumpE", {31'h0, JumpE}, 32'h1);
    chk("jal ResultSrcE", {30'h0, ResultSrcE}, 32'h2);
    chk("jal ImmExtE", ImmExtE, 32'h8);
    chk("jal PCE", PCE, 32'h200);
    chk("jal PCPlus4E", PCPlus4E, 32'h204);

    // x0 protection: WB to x0 is dropped and never bypassed.
    step(32'h00000113, 32'h204, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    chk("x0 same cycle", RD1E, 32'h0);
    run(32'h00000113, 32'h208);
    chk("x0 after", RD1E, 32'h0);

    // Flush with lw x5,4(x6) while WB writes x7.
    step(32'h00432283, 32'h20C, 1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678);
    chk_bubble("flush");
    run({7'h0, 5'd0, 5'd7, 3'b000, 5'd8, 7'h33}, 32'h210); // add x8,x7,x0
    chk("flush wb landed", RD1E, 32'h12345678);

    // Flush and reset together.
    step(32'h00432283, 32'h214, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    chk_bubble("flush+reset");
    run({7'h0, 5'd0, 5'd7, 3'b000, 5'd8, 7'h33}, 32'h218);
    chk("x7 cleared by reset", RD1E, 32'h0);

    // Illegal instruction.
    run(32'hFFFFFFFF, 32'h21C);
    chk("illegal IllegalE", {31'h0, IllegalE}, 32'h1);
    chk("illegal ctrl", {28'h0, RegWriteE, MemWriteE, BranchE, JumpE}, 32'h0);
    chk("illegal RdE still loaded", {27'h0, RdE}, 32'h1F);

    // Pin the reference decode on a few hand-computed encodings.
    chk("model beq imm", decode(32'hFE208EE3).imm, 32'hFFFFFFFC);
    chk("model lw imm", decode(32'h00432283).imm, 32'h4);
    chk("model slli illegal", {31'h0, decode(32'h00109093).illegal}, 32'h1);

    // Table-driven mix: each supported opcode plus an unknown one, with
    // random upper bits and random WB traffic.
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b1010101;
    for (int n = 0; n < 60; n++) begin
      instr = {$urandom()} & 32'hFFFFFF80;
      instr[6:0] = ops[$urandom_range(0, 6)];
      step(instr, 32'h1000 + 32'(n * 4), ($urandom_range(0, 9) == 0),
           1'b0, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
           $urandom());
    end

    // Drain and report.
    run(32'h00000013, 32'h0);
    @(posedge clk);
    #3;
    chk("queue drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idecode.md
Name: idecode

Overview:
Decode (ID) stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes its IF/ID register outputs (InstrD, PCD, PCPlus4D). It contains the main/ALU control decoder, the immediate extender, a 32x32 register file written back from WB, and the ID/EX pipeline register feeding the execute stage. Rs1D/Rs2D are exported unregistered to the hazard unit.

Parameters:
XLEN, 32, data/address width
NREGS, 32, register file depth; x0 is hardwired to zero

Ports:
clk  in  1  pipeline clock, rising-edge
reset  in  1  synchronous, active-high; clears register file and ID/EX register
FlushE  in  1  synchronous bubble insert into ID/EX (from hazard unit)
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  WB write enable
RdW  in  5  WB destination register
ResultW  in  32  WB write data
Rs1D  out  5  InstrD[19:15], combinational, to hazard unit
Rs2D  out  5  InstrD[24:20], combinational, to hazard unit
RegWriteE  out  1  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
MemWriteE  out  1  store enable
JumpE  out  1  jal
BranchE  out  1  beq
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcE  out  1  0 = RD2, 1 = immediate
IllegalE  out  1  unsupported opcode/funct seen in ID
RD1E, RD2E  out  32  register operands
ImmExtE  out  32  sign-extended immediate
Rs1E, Rs2E, RdE  out  5  register indices
PCE, PCPlus4E  out  32  forwarded PCs

Behaviour:
- Latency: every E output equals the decode of the InstrD present at the previous rising edge (1 cycle). No stall input; the ID/EX register loads every cycle.
- Reset (sync, highest priority): all E outputs and all 32 registers are 0 at the next edge. Reset mid-stream discards the in-flight decode.
- FlushE=1 (reset=0): all E outputs are 0 at the next edge (bubble). The register-file write from WB still occurs. reset together with FlushE behaves as reset.
- Decoder, by opcode:
  - lw (0000011): RegWrite=1, ResultSrc=01, ALUSrc=1, ImmSrc I, ALU add.
  - sw (0100011): MemWrite=1, ALUSrc=1, ImmSrc S, ALU add.
  - R-type (0110011), by funct3/funct7[5]: add 000/0, sub 000/1, slt 010, or 110, and 111. RegWrite=1.
  - I-ALU (0010011): addi, slti, ori, andi, same encodings as R-type. funct7[5] is ignored (addi never subtracts). ALUSrc=1.
  - beq (1100011, funct3 000): Branch=1, ALU sub, ImmSrc B.
  - jal (1101111): Jump=1, RegWrite=1, ResultSrc=10, ImmSrc J.
  - Any other opcode/funct combination: all control signals 0 and IllegalE=1. Data fields are still registered.
- Immediates, all sign-extended from InstrD[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - For R-type, ImmExtE is don't-care and is driven 0.
- Register file:
  - Two combinational read ports, addressed by Rs1D and Rs2D.
  - Write on the rising edge when RegWriteW=1 and RdW!=0.
  - Writes to x0 are ignored; a read of x0 always returns 0.
  - Write-through: a same-cycle read of RdW (RdW!=0, RegWriteW=1) returns ResultW. WB-to-ID needs no stall.
- RdE = InstrD[11:7] regardless of opcode; the hazard unit qualifies it with RegWriteE.

Test Plan:
- Reset: reset=1 for 2 cycles with InstrD=0x00500093 -> all E outputs 0, IllegalE=0. Reading x1..x31 afterwards returns 0.
- addi x1,x0,5 (0x00500093) -> next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, Rs1E=0, RD1E=0. Then write back (RegWriteW=1, RdW=1, ResultW=5) while InstrD=sub x3,x1,x2 (0x402081B3) -> RD1E=5 via write-through, ALUControlE=001, RdE=3.
- Immediates: sw x2,8(x1) (0x0020A423) -> MemWriteE=1, RegWriteE=0, ImmExtE=8. beq x1,x2,-4 (0xFE208EE3) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC. jal x1,8 (0x008000EF) -> JumpE=1, ResultSrcE=10, ImmExtE=8, with PCE/PCPlus4E equal to the PCD/PCPlus4D applied one cycle earlier.
- x0 protection: RegWriteW=1, RdW=0, ResultW=0xDEADBEEF, and an instruction reading x0 -> RD1E=0 both in that cycle and afterwards.
- Flush: FlushE=1 with InstrD=lw x5,4(x6) (0x00432283) -> all E outputs 0 next cycle, while a concurrent WB write to x7 still lands. FlushE and reset asserted together -> all E outputs 0.
- Illegal: InstrD=0xFFFFFFFF -> IllegalE=1, RegWriteE=MemWriteE=BranchE=JumpE=0.
